carry_skip_sub32_pipe: RTL

Pipelined 32-bit carry-skip subtractor computing `a - b - bin` with a valid/ready handshake on both sides. It is the inverse-direction companion to the 32-bit carry-skip adder. Groups of 4 bits form `a + ~b + ~bin`, and each group skips the carry when all 4 propagate bits are set. Pipeline registers sit between group clusters, so a 32-bit difference streams out at one result per clock. It feeds the datapath compare and decrement units.

---
 rtl/cska_pkg.sv | 11 +
 rtl/carry_skip_sub4.sv | 34 +++
 rtl/carry_skip_sub32_pipe.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cska_pkg.sv
// Shared constants and types for the carry-skip add/sub family.
//   CSKA_WIDTH   : datapath width
//   CSKA_GROUP_W : bits per skip group
//   CSKA_NGROUPS : skip groups across the datapath
package cska_pkg;
    localparam int CSKA_WIDTH   = 32;
    localparam int CSKA_GROUP_W = 4;
    localparam int CSKA_NGROUPS = CSKA_WIDTH / CSKA_GROUP_W;

    typedef logic [CSKA_GROUP_W-1:0] cska_slice_t;
endpackage

// File: rtl/carry_skip_sub4.sv
// 4-bit carry-skip subtract slice: diff = a + ~b + cin, with the group
// carry bypassed when every propagate bit is set.
//   a, b  : operand slices
//   cin   : carry in (inverted borrow)
//   diff  : difference slice
//   cout  : carry out (inverted borrow)
module carry_skip_sub4
    import cska_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] diff,
    output logic       cout
);
    cska_slice_t p;
    cska_slice_t bn;
    logic [4:0]  c;
    logic        bp;

    assign bn   = ~b;
    assign p    = a ^ bn;
    assign c[0] = cin;

    for (genvar i = 0; i < CSKA_GROUP_W; i++) begin : g_fa
        assign diff[i]  = p[i] ^ c[i];
        assign c[i+1]   = (a[i] & bn[i]) | (p[i] & c[i]);
    end

    // All-propagate group passes cin straight through, cutting the ripple
    // out of the critical path.
    assign bp   = &p;
    assign cout = bp ? cin : c[4];
endmodule

// File: rtl/carry_skip_sub32_pipe.sv
// Pipelined 32-bit carry-skip subtractor: diff = a - b - bin.
// Each stage evaluates GROUPS_PER_STAGE skip groups; one result per clock.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : operand handshake (in_ready comb. from out_ready)
//   a, b, bin           : minuend, subtrahend, borrow in
//   out_valid/out_ready : result handshake
//   diff, bout, ovf     : difference, borrow out, signed overflow
// Optional: define CSKS_OVF_EN to carry operand sign bits and drive ovf;
// otherwise ovf is tied 0.
module carry_skip_sub32_pipe
    import cska_pkg::*;
#(
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] diff,
    output logic        bout,
    output logic        ovf
);
    localparam int NSTG = CSKA_NGROUPS / GROUPS_PER_STAGE;
    localparam int GPS  = GROUPS_PER_STAGE;
    localparam int W    = CSKA_WIDTH;
    localparam int GW   = CSKA_GROUP_W;

    logic [NSTG-1:0] vld;
    logic            adv;

    // Stage registers. The carry between stages is stored as a borrow
    // (st_w = ~carry) so the reset value 0 reads as bout=0.
    logic [W-1:0] st_a [NSTG];
    logic [W-1:0] st_b [NSTG];
    logic [W-1:0] st_d [NSTG];
    logic         st_w [NSTG];

    // Inputs seen by each stage's group cluster.
    logic [W-1:0] src_a [NSTG];
    logic [W-1:0] src_b [NSTG];
    logic [W-1:0] src_d [NSTG];
    logic         src_c [NSTG];

    logic [W-1:0] nxt_d [NSTG];
    logic         nxt_w [NSTG];

    logic         gcin  [CSKA_NGROUPS];
    logic         gcout [CSKA_NGROUPS];
    cska_slice_t  gdiff [CSKA_NGROUPS];

    assign adv       = ~vld[NSTG-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[NSTG-1];
    assign diff      = st_d[NSTG-1];
    assign bout      = st_w[NSTG-1];

    for (genvar k = 0; k < NSTG; k++) begin : g_src
        if (k == 0) begin : g_first
            assign src_a[k] = a;
            assign src_b[k] = b;
            assign src_d[k] = '0;
            assign src_c[k] = ~bin;
        end else begin : g_rest
            assign src_a[k] = st_a[k-1];
            assign src_b[k] = st_b[k-1];
            assign src_d[k] = st_d[k-1];
            assign src_c[k] = ~st_w[k-1];
        end
    end

    for (genvar g = 0; g < CSKA_NGROUPS; g++) begin : g_grp
        localparam int K = g / GPS;
        // First group of a stage takes the carry registered by the
        // previous stage; others chain within the stage.
        if ((g % GPS) == 0) begin : g_cin_reg
            assign gcin[g] = src_c[K];
        end else begin : g_cin_chain
            assign gcin[g] = gcout[g-1];
        end

        carry_skip_sub4 u_grp (
            .a    (src_a[K][g*GW +: GW]),
            .b    (src_b[K][g*GW +: GW]),
            .cin  (gcin[g]),
            .diff (gdiff[g]),
            .cout (gcout[g])
        );
    end

    // Merge this stage's fresh difference bits over the completed lower bits.
    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            nxt_d[k] = src_d[k];
            for (int j = 0; j < GPS; j++) begin
                nxt_d[k][(k*GPS+j)*GW +: GW] = gdiff[k*GPS+j];
            end
            nxt_w[k] = ~gcout[k*GPS+GPS-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < NSTG; k++) begin
                st_a[k] <= '0;
                st_b[k] <= '0;
                st_d[k] <= '0;
                st_w[k] <= 1'b0;
            end
        end else if (adv) begin
            vld[0] <= in_valid;
            for (int k = 1; k < NSTG; k++) vld[k] <= vld[k-1];
            for (int k = 0; k < NSTG; k++) begin
                st_a[k] <= src_a[k];
                st_b[k] <= src_b[k];
                st_d[k] <= nxt_d[k];
                st_w[k] <= nxt_w[k];
            end
        end
    end

`ifdef CSKS_OVF_EN
    // Operand sign bits ride alongside the data to the last stage.
    logic st_sa [NSTG];
    logic st_sb [NSTG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                st_sa[k] <= 1'b0;
                st_sb[k] <= 1'b0;
            end
        end else if (adv) begin
            st_sa[0] <= a[W-1];
            st_sb[0] <= b[W-1];
            for (int k = 1; k < NSTG; k++) begin
                st_sa[k] <= st_sa[k-1];
                st_sb[k] <= st_sb[k-1];
            end
        end
    end

    assign ovf = (st_sa[NSTG-1] ^ st_sb[NSTG-1]) & (st_sa[NSTG-1] ^ st_d[NSTG-1][W-1]);
`else
    assign ovf = 1'b0;
`endif
endmodule
